// File: rtl/frogger_pkg.sv
// rtl/frogger_pkg.sv - shared frogger types, key codes and keycode decode helpers
package frogger_pkg;

   typedef enum logic [1:0] {DIR_UP, DIR_DOWN, DIR_LEFT, DIR_RIGHT} dir_t;

   // Auto-repeat phase: waiting for the long first delay, or repeating at the short period
   typedef enum logic {PH_FIRST, PH_REPEAT} phase_t;

   localparam logic [7:0] KEY_W = 8'h1A;
   localparam logic [7:0] KEY_S = 8'h16;
   localparam logic [7:0] KEY_A = 8'h04;
   localparam logic [7:0] KEY_D = 8'h07;

   localparam int CNT_W = 8;

   // One USB keycode byte to a {right,left,down,up} mask
   function automatic logic [3:0] decode_key(input logic [7:0] k);
      logic [3:0] m;
      m = 4'b0000;
      case (k)
         KEY_W:   m = 4'b0001;
         KEY_S:   m = 4'b0010;
         KEY_A:   m = 4'b0100;
         KEY_D:   m = 4'b1000;
         default: m = 4'b0000;
      endcase
      return m;
   endfunction

   // Highest-priority direction in a mask, UP > DOWN > LEFT > RIGHT
   function automatic dir_t prio_dir(input logic [3:0] m);
      dir_t d;
      if (m[0])      d = DIR_UP;
      else if (m[1]) d = DIR_DOWN;
      else if (m[2]) d = DIR_LEFT;
      else           d = DIR_RIGHT;
      return d;
   endfunction

endpackage

// File: rtl/keycode_hop_ctrl_if.sv
// rtl/keycode_hop_ctrl_if.sv - hop command valid/ready handshake bundle
interface keycode_hop_ctrl_if;
   import frogger_pkg::*;

   logic hop_valid;
   logic hop_ready;
   dir_t hop_dir;

   modport master (output hop_valid, output hop_dir, input hop_ready);
   modport slave  (input hop_valid, input hop_dir, output hop_ready);

endinterface

// File: rtl/keycode_hop_ctrl_hop_fifo.sv
// rtl/keycode_hop_ctrl_hop_fifo.sv - small hop command FIFO with sticky overflow
module hop_fifo
   import frogger_pkg::*;
#(
   parameter int  DEPTH = 4,
   parameter type T     = dir_t
) (
   input  logic Clk,
   input  logic Reset,
   input  logic push,
   input  T     din,
   input  logic pop,
   output T     dout,
   output logic empty,
   output logic full,
   output logic overflow
);

   localparam int AW = $clog2(DEPTH);

   T               mem [DEPTH];
   logic [AW-1:0]  wr_ptr;
   logic [AW-1:0]  rd_ptr;
   logic [AW:0]    count;
   logic           do_push;

   assign empty   = (count == '0);
   assign full    = (count == (AW+1)'(DEPTH));
   // A full FIFO still accepts a push when the head leaves in the same cycle
   assign do_push = push & (~full | pop);
   assign dout    = mem[rd_ptr];

   // Storage, wrapping pointers, occupancy and the sticky drop flag
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= T'(0);
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= din;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         if (push & full & ~pop) overflow <= 1'b1;
      end
   end

endmodule

// File: rtl/keycode_hop_ctrl.sv
// rtl/keycode_hop_ctrl.sv - USB keycode word to queued frog hop commands
module keycode_hop_ctrl
   import frogger_pkg::*;
#(
   parameter int DEPTH         = 4,
   parameter int REPEAT_DELAY  = 20,
   parameter int REPEAT_PERIOD = 8,
   parameter int GAP_FRAMES    = 1
) (
   input  logic                      Clk,
   input  logic                      Reset,
   input  logic [15:0]               keycode,
   input  logic                      frame_clk,
   keycode_hop_ctrl_if.master        hop,
   output logic [3:0]                held,
   output logic                      overflow
);

   logic [15:0]      kc_q;
   logic [3:0]       pressed;
   logic [3:0]       new_keys;
   logic [2:0]       fs;
   logic             tick;
   logic             press_fire;
   logic             rep_fire;
   logic             push;
   logic             pop;
   logic             empty;
   logic             full;
   dir_t             din;
   dir_t             head;
   phase_t           phase, phase_nxt;
   logic [CNT_W-1:0] rep_cnt, rep_cnt_nxt;
   logic [CNT_W-1:0] rep_limit;
   logic [CNT_W-1:0] gap_cnt;

   assign pressed    = decode_key(kc_q[7:0]) | decode_key(kc_q[15:8]);
   assign new_keys   = pressed & ~held;
   assign press_fire = |new_keys;
   // frame_clk is only a tick source: two sync flops, third flop for the rising edge
   assign tick       = fs[1] & ~fs[2];
   // A press and a repeat in the same cycle collapse into the press entry
   assign push       = press_fire | rep_fire;
   assign din        = press_fire ? prio_dir(new_keys) : prio_dir(held);

   assign hop.hop_valid = ~empty & (gap_cnt == '0);
   assign hop.hop_dir   = head;
   assign pop           = hop.hop_valid & hop.hop_ready;

   // Input capture, held-key history and vsync synchronizer
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         kc_q <= '0;
         held <= '0;
         fs   <= '0;
      end else begin
         kc_q <= keycode;
         held <= pressed;
         fs   <= {fs[1:0], frame_clk};
      end
   end

   // Auto-repeat state register
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         phase   <= PH_FIRST;
         rep_cnt <= '0;
      end else begin
         phase   <= phase_nxt;
         rep_cnt <= rep_cnt_nxt;
      end
   end

   // Auto-repeat next state: count frame ticks only while exactly one key is steadily held
   always_comb begin
      phase_nxt   = phase;
      rep_cnt_nxt = rep_cnt;
      rep_fire    = 1'b0;
      rep_limit   = (phase == PH_FIRST) ? CNT_W'(REPEAT_DELAY) : CNT_W'(REPEAT_PERIOD);
      if (pressed != held) begin
         rep_cnt_nxt = '0;
         phase_nxt   = PH_FIRST;
      end else if ($countones(held) != 1) begin
         rep_cnt_nxt = '0;
      end else if (tick) begin
         if (rep_cnt + 1'b1 == rep_limit) begin
            rep_fire    = 1'b1;
            rep_cnt_nxt = '0;
            phase_nxt   = PH_REPEAT;
         end else begin
            rep_cnt_nxt = rep_cnt + 1'b1;
         end
      end
   end

   // Post-handshake gap: reload on every accepted hop, count down on frame ticks
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset)                       gap_cnt <= '0;
      else if (pop)                    gap_cnt <= CNT_W'(GAP_FRAMES);
      else if (tick && gap_cnt != '0)  gap_cnt <= gap_cnt - 1'b1;
   end

   hop_fifo #(.DEPTH(DEPTH), .T(dir_t)) u_fifo (
      .Clk      (Clk),
      .Reset    (Reset),
      .push     (push),
      .din      (din),
      .pop      (pop),
      .dout     (head),
      .empty    (empty),
      .full     (full),
      .overflow (overflow)
   );

endmodule

// File: tb/tb_keycode_hop_ctrl.sv
// tb/tb_keycode_hop_ctrl.sv - directed self-checking bench for keycode_hop_ctrl
module tb_keycode_hop_ctrl;
   import frogger_pkg::*;

   logic        Clk = 1'b0;
   logic        Reset;
   logic [15:0] keycode;
   logic        frame_clk;
   logic [3:0]  held;
   logic        overflow;

   keycode_hop_ctrl_if hop_if ();

   keycode_hop_ctrl dut (
      .Clk       (Clk),
      .Reset     (Reset),
      .keycode   (keycode),
      .frame_clk (frame_clk),
      .hop       (hop_if.master),
      .held      (held),
      .overflow  (overflow)
   );

   always #5 Clk = ~Clk;

   int n_vec = 0;
   int n_err = 0;
   int cyc = 0;
   int tick_idx = 0;
   int pop_dir [$];
   int pop_cyc [$];
   int pop_tick [$];

   always @(posedge Clk) cyc <= cyc + 1;

   // Accepted hops are logged at the falling edge, clear of the active edge
   always @(negedge Clk) begin
      if (!Reset && hop_if.hop_valid && hop_if.hop_ready) begin
         pop_dir.push_back(int'(hop_if.hop_dir));
         pop_cyc.push_back(cyc);
         pop_tick.push_back(tick_idx);
      end
   end

   task automatic check_vec(input string tag, input int obs, input int exp);
      n_vec++;
      if (obs != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge Clk);
      #2;
   endtask

   task automatic frame_tick(input int hi, input int lo);
      frame_clk = 1'b1;
      tick_idx++;
      step(hi);
      frame_clk = 1'b0;
      step(lo);
   endtask

   task automatic press(input logic [15:0] k);
      keycode = k;
      step(3);
      keycode = 16'h0000;
      step(3);
   endtask

   task automatic clear_log();
      pop_dir.delete();
      pop_cyc.delete();
      pop_tick.delete();
   endtask

   int c0;
   int base;
   int exp_dir [5];
   int exp_rel [4];

   initial begin
      Reset = 1'b1;
      keycode = 16'h0000;
      frame_clk = 1'b0;
      hop_if.hop_ready = 1'b0;
      step(2);
      check_vec("rst_valid", int'(hop_if.hop_valid), 0);
      check_vec("rst_dir", int'(hop_if.hop_dir), 0);
      check_vec("rst_held", int'(held), 0);
      check_vec("rst_ovf", int'(overflow), 0);
      Reset = 1'b0;
      step(2);

      // 1: single UP press, held without ticks
      hop_if.hop_ready = 1'b1;
      clear_log();
      c0 = cyc;
      keycode = 16'h001A;
      step(100);
      check_vec("t1_pops", pop_dir.size(), 1);
      if (pop_dir.size() > 0) begin
         check_vec("t1_dir", pop_dir[0], int'(DIR_UP));
         check_vec("t1_latency", pop_cyc[0] - c0, 2);
      end
      check_vec("t1_held", int'(held), 4'b0001);
      keycode = 16'h0000;
      step(3);

      // 2: LEFT+RIGHT together, one LEFT entry, no repeat
      clear_log();
      keycode = 16'h0704;
      step(5);
      for (int i = 0; i < 50; i++) frame_tick(4, 4);
      check_vec("t2_pops", pop_dir.size(), 1);
      if (pop_dir.size() > 0) check_vec("t2_dir", pop_dir[0], int'(DIR_LEFT));
      check_vec("t2_held", int'(held), 4'b1100);
      keycode = 16'h0000;
      step(3);

      // 3: held DOWN, repeats at ticks 20, 28, 36
      clear_log();
      base = tick_idx;
      keycode = 16'h0016;
      step(5);
      for (int i = 0; i < 40; i++) frame_tick(50, 50);
      exp_rel = '{0, 20, 28, 36};
      check_vec("t3_pops", pop_dir.size(), 4);
      for (int i = 0; i < 4; i++) begin
         if (pop_dir.size() > i) begin
            check_vec($sformatf("t3_dir%0d", i), pop_dir[i], int'(DIR_DOWN));
            check_vec($sformatf("t3_tick%0d", i), pop_tick[i] - base, exp_rel[i]);
         end
      end
      keycode = 16'h0000;
      step(3);

      // 4: fill with ready low, fifth press overflows, then drain one per tick
      hop_if.hop_ready = 1'b0;
      press(16'h001A);
      press(16'h0016);
      press(16'h0004);
      press(16'h0007);
      check_vec("t4_ovf_full", int'(overflow), 0);
      check_vec("t4_valid", int'(hop_if.hop_valid), 1);
      check_vec("t4_head", int'(hop_if.hop_dir), int'(DIR_UP));
      press(16'h001A);
      check_vec("t4_ovf", int'(overflow), 1);
      clear_log();
      base = tick_idx;
      hop_if.hop_ready = 1'b1;
      step(2);
      for (int i = 0; i < 5; i++) frame_tick(4, 4);
      check_vec("t4_pops", pop_dir.size(), 4);
      for (int i = 0; i < 4; i++) begin
         if (pop_dir.size() > i) begin
            check_vec($sformatf("t4_dir%0d", i), pop_dir[i], i);
            check_vec($sformatf("t4_tick%0d", i), pop_tick[i] - base, i);
         end
      end
      check_vec("t4_ovf_sticky", int'(overflow), 1);

      // 6: reset mid-queue with RIGHT held
      hop_if.hop_ready = 1'b0;
      press(16'h001A);
      press(16'h0016);
      keycode = 16'h0007;
      step(3);
      Reset = 1'b1;
      #1;
      check_vec("t6_rst_valid", int'(hop_if.hop_valid), 0);
      check_vec("t6_rst_ovf", int'(overflow), 0);
      check_vec("t6_rst_held", int'(held), 0);
      step(1);
      Reset = 1'b0;
      step(3);
      check_vec("t6_valid", int'(hop_if.hop_valid), 1);
      check_vec("t6_dir", int'(hop_if.hop_dir), int'(DIR_RIGHT));
      check_vec("t6_held", int'(held), 4'b1000);
      clear_log();
      hop_if.hop_ready = 1'b1;
      step(2);
      keycode = 16'h0000;
      for (int i = 0; i < 3; i++) frame_tick(4, 4);
      check_vec("t6_pops", pop_dir.size(), 1);
      if (pop_dir.size() > 0) check_vec("t6_pop_dir", pop_dir[0], int'(DIR_RIGHT));

      // 5: full FIFO, push and pop in the same cycle
      hop_if.hop_ready = 1'b0;
      press(16'h001A);
      press(16'h0016);
      press(16'h0004);
      press(16'h0007);
      clear_log();
      keycode = 16'h0016;
      step(1);
      hop_if.hop_ready = 1'b1;
      step(1);
      check_vec("t5_ovf", int'(overflow), 0);
      check_vec("t5_gap", int'(hop_if.hop_valid), 0);
      step(2);
      keycode = 16'h0000;
      for (int i = 0; i < 6; i++) frame_tick(4, 4);
      exp_dir = '{0, 1, 2, 3, 1};
      check_vec("t5_pops", pop_dir.size(), 5);
      for (int i = 0; i < 5; i++) begin
         if (pop_dir.size() > i) check_vec($sformatf("t5_dir%0d", i), pop_dir[i], exp_dir[i]);
      end
      check_vec("t5_ovf_end", int'(overflow), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
